lsu_axi_gpio_slave: RTL and testbench

AXI4 write-only slave that terminates the core's LSU write channel in the Caravel user area and turns stores into registered GPIO output and output-enable values. It sits directly downstream of the core's `lsu_axi_aw*`/`w*`/`b*` ports and replaces tied-off `awready`/`wready`/`bvalid` with a real handshake and response. Decoded stores update `io_out`/`io_oeb`; the last accepted 32-bit word is mirrored for the logic analyzer.

---
 rtl/lsu_gpio_pkg.sv | 33 +++
 rtl/lsu_gpio_regs.sv | 54 +++++
 rtl/lsu_axi_gpio_slave.sv | 148 ++++++++++++++
 tb/tb_lsu_axi_gpio_slave.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_gpio_pkg.sv
// rtl/lsu_gpio_pkg.sv - shared types, response codes and byte-strobe merge for lsu_axi_gpio_slave
package lsu_gpio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int REG_W    = 32;
  localparam int LANE_OUT = 0;
  localparam int LANE_OE  = 1;
  localparam int OFFSET_W = 3;

  localparam logic [2:0] MAX_SIZE = 3'd3;

  function automatic logic [REG_W-1:0] strb_merge(
    input logic [REG_W-1:0]   old_v,
    input logic [REG_W-1:0]   new_v,
    input logic [REG_W/8-1:0] strb
  );
    logic [REG_W-1:0] res;
    for (int b = 0; b < REG_W / 8; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_gpio_regs.sv
// rtl/lsu_gpio_regs.sv - OUT/OE registers, store mirror and write counter behind lsu_axi_gpio_slave
module lsu_gpio_regs
  import lsu_gpio_pkg::*;
#(
  parameter int GPIO_W = 28
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              we,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oeb,
  output logic [31:0]       la_wdata,
  output logic [15:0]       wr_cnt
);

  logic [REG_W-1:0]   out_q;
  logic [REG_W-1:0]   oe_q;
  logic [REG_W-1:0]   la_q;
  logic [15:0]        cnt_q;
  logic [REG_W-1:0]   data_out;
  logic [REG_W-1:0]   data_oe;
  logic [REG_W/8-1:0] strb_out;
  logic [REG_W/8-1:0] strb_oe;
  logic               oe_lane_only;

  assign data_out     = wdata[LANE_OUT*REG_W +: REG_W];
  assign data_oe      = wdata[LANE_OE*REG_W +: REG_W];
  assign strb_out     = wstrb[LANE_OUT*(REG_W/8) +: REG_W/8];
  assign strb_oe      = wstrb[LANE_OE*(REG_W/8) +: REG_W/8];
  // The mirror follows the OE lane only for stores that touch nothing but that lane.
  assign oe_lane_only = (strb_out == '0) && (strb_oe != '0);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_q <= '0;
      oe_q  <= '0;
      la_q  <= '0;
      cnt_q <= '0;
    end else if (we) begin
      out_q <= strb_merge(out_q, data_out, strb_out);
      oe_q  <= strb_merge(oe_q, data_oe, strb_oe);
      la_q  <= oe_lane_only ? data_oe : data_out;
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign gpio_out = out_q[GPIO_W-1:0];
  assign gpio_oeb = ~oe_q[GPIO_W-1:0];
  assign la_wdata = la_q;
  assign wr_cnt   = cnt_q;

endmodule

// File: rtl/lsu_axi_gpio_slave.sv
// rtl/lsu_axi_gpio_slave.sv - single-outstanding AXI4 write slave turning LSU stores into GPIO pad values
module lsu_axi_gpio_slave
  import lsu_gpio_pkg::*;
#(
  parameter int          ID_W      = 3,
  parameter int          GPIO_W    = 28,
  parameter logic [31:0] BASE_ADDR = 32'hD000_0000
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              lsu_axi_awvalid,
  output logic              lsu_axi_awready,
  input  logic [ID_W-1:0]   lsu_axi_awid,
  input  logic [31:0]       lsu_axi_awaddr,
  input  logic [2:0]        lsu_axi_awsize,
  input  logic              lsu_axi_wvalid,
  output logic              lsu_axi_wready,
  input  logic [63:0]       lsu_axi_wdata,
  input  logic [7:0]        lsu_axi_wstrb,
  input  logic              lsu_axi_wlast,
  output logic              lsu_axi_bvalid,
  input  logic              lsu_axi_bready,
  output logic [1:0]        lsu_axi_bresp,
  output logic [ID_W-1:0]   lsu_axi_bid,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oeb,
  output logic [31:0]       la_wdata,
  output logic [15:0]       wr_cnt
);

  state_t               state_q, state_d;
  logic                 out_of_rst_q;
  logic                 aw_held_q, w_held_q;
  logic [ID_W-1:0]      awid_q;
  logic [31:OFFSET_W]   awaddr_q;
  logic [2:0]           awsize_q;
  logic [63:0]          wdata_q;
  logic [7:0]           wstrb_q;
  logic [ID_W-1:0]      bid_q;
  logic [1:0]           bresp_q;
  logic                 aw_hs, w_hs, b_hs;
  logic                 regs_we;
  logic [1:0]           exec_resp;
  logic                 unused_bits;

  assign aw_hs = lsu_axi_awvalid & lsu_axi_awready;
  assign w_hs  = lsu_axi_wvalid & lsu_axi_wready;
  assign b_hs  = lsu_axi_bvalid & lsu_axi_bready;

  // Address decode outranks the size check, so an off-window oversize store reports DECERR.
  assign exec_resp = (awaddr_q != BASE_ADDR[31:OFFSET_W]) ? RESP_DECERR :
                     (awsize_q > MAX_SIZE)                ? RESP_SLVERR : RESP_OKAY;

  assign unused_bits = ^{lsu_axi_wlast, lsu_axi_awaddr[OFFSET_W-1:0]};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= ST_IDLE;
      out_of_rst_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_of_rst_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (lsu_axi_bready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lsu_axi_awready = 1'b0;
    lsu_axi_wready  = 1'b0;
    lsu_axi_bvalid  = 1'b0;
    regs_we         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        lsu_axi_awready = ~aw_held_q & out_of_rst_q;
        lsu_axi_wready  = ~w_held_q & out_of_rst_q;
      end
      ST_EXEC: regs_we = (exec_resp == RESP_OKAY);
      ST_RESP: lsu_axi_bvalid = 1'b1;
      default: ;
    endcase
  end

  // AW and W land in independent holding registers; both clear only on the B handshake.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awid_q    <= lsu_axi_awid;
        awaddr_q  <= lsu_axi_awaddr[31:OFFSET_W];
        awsize_q  <= lsu_axi_awsize;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= lsu_axi_wdata;
        wstrb_q  <= lsu_axi_wstrb;
      end
      if (b_hs) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bid_q   <= '0;
      bresp_q <= RESP_OKAY;
    end else if (state_q == ST_EXEC) begin
      bid_q   <= awid_q;
      bresp_q <= exec_resp;
    end
  end

  assign lsu_axi_bid   = bid_q;
  assign lsu_axi_bresp = bresp_q;

  lsu_gpio_regs #(
    .GPIO_W (GPIO_W)
  ) u_regs (
    .clk      (clk),
    .rst_l    (rst_l),
    .we       (regs_we),
    .wdata    (wdata_q),
    .wstrb    (wstrb_q),
    .gpio_out (gpio_out),
    .gpio_oeb (gpio_oeb),
    .la_wdata (la_wdata),
    .wr_cnt   (wr_cnt)
  );

endmodule

// File: tb/tb_lsu_axi_gpio_slave.sv
// tb/tb_lsu_axi_gpio_slave.sv - directed scoreboard bench for lsu_axi_gpio_slave
module tb_lsu_axi_gpio_slave;

  localparam logic [31:0] BASE = 32'hD000_0000;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        awvalid, awready;
  logic [2:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [2:0]  bid;
  logic [27:0] gpio_out, gpio_oeb;
  logic [31:0] la_wdata;
  logic [15:0] wr_cnt;

  always #5 clk = ~clk;

  lsu_axi_gpio_slave dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .lsu_axi_awvalid (awvalid),
    .lsu_axi_awready (awready),
    .lsu_axi_awid    (awid),
    .lsu_axi_awaddr  (awaddr),
    .lsu_axi_awsize  (awsize),
    .lsu_axi_wvalid  (wvalid),
    .lsu_axi_wready  (wready),
    .lsu_axi_wdata   (wdata),
    .lsu_axi_wstrb   (wstrb),
    .lsu_axi_wlast   (wlast),
    .lsu_axi_bvalid  (bvalid),
    .lsu_axi_bready  (bready),
    .lsu_axi_bresp   (bresp),
    .lsu_axi_bid     (bid),
    .gpio_out        (gpio_out),
    .gpio_oeb        (gpio_oeb),
    .la_wdata        (la_wdata),
    .wr_cnt          (wr_cnt)
  );

  typedef struct packed {
    logic [2:0]  id;
    logic [1:0]  resp;
    logic [27:0] gout;
    logic [27:0] goeb;
    logic [15:0] cnt;
    logic [31:0] la;
  } exp_t;

  exp_t        sb[$];
  exp_t        held;
  logic [31:0] out_m, oe_m, la_m;
  logic [15:0] cnt_m;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    out_m = '0;
    oe_m  = '0;
    la_m  = '0;
    cnt_m = '0;
    sb.delete();
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [31:0] addr, input logic [2:0] size,
                          input logic [63:0] data, input logic [7:0] strb);
    exp_t e;
    e.id = id;
    if (addr[31:3] != BASE[31:3]) e.resp = 2'b11;
    else if (size > 3'd3)         e.resp = 2'b10;
    else                          e.resp = 2'b00;
    if (e.resp == 2'b00) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b])     out_m[8*b +: 8] = data[8*b +: 8];
        if (strb[b + 4]) oe_m[8*b +: 8]  = data[32 + 8*b +: 8];
      end
      la_m  = (strb[3:0] == 4'h0 && strb[7:4] != 4'h0) ? data[63:32] : data[31:0];
      cnt_m = cnt_m + 16'd1;
    end
    e.gout = out_m[27:0];
    e.goeb = ~oe_m[27:0];
    e.cnt  = cnt_m;
    e.la   = la_m;
    sb.push_back(e);
  endtask

  task automatic check_b();
    chk("bvalid", bvalid, 1'b1);
    chk("sb_nonempty", sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      held = sb.pop_front();
      chk("bid", bid, held.id);
      chk("bresp", bresp, held.resp);
      chk("gpio_out", gpio_out, held.gout);
      chk("gpio_oeb", gpio_oeb, held.goeb);
      chk("wr_cnt", wr_cnt, held.cnt);
      chk("la_wdata", la_wdata, held.la);
    end
  endtask

  task automatic drive_aw(input logic [2:0] id, input logic [31:0] addr, input logic [2:0] size);
    awvalid = 1'b1; awid = id; awaddr = addr; awsize = size;
  endtask

  task automatic drive_w(input logic [63:0] data, input logic [7:0] strb);
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = 1'b1;
  endtask

  // Waits for the requested ready(s) at negedges, lets one posedge handshake, drops valids.
  task automatic handshake(input string tag, input logic need_aw, input logic need_w);
    for (int i = 0; i < 20 && !((awready || !need_aw) && (wready || !need_w)); i++) @(negedge clk);
    chk(tag, (awready || !need_aw) && (wready || !need_w), 1'b1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic b_accept();
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] id, input logic [31:0] addr, input logic [2:0] size,
                          input logic [63:0] data, input logic [7:0] strb);
    push_exp(id, addr, size, data, strb);
    drive_aw(id, addr, size);
    drive_w(data, strb);
    handshake("hs_both", 1'b1, 1'b1);
    chk("exec_bvalid", bvalid, 1'b0);
    chk("exec_awready", awready, 1'b0);
    @(negedge clk);
    check_b();
    b_accept();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    awid = '0; awaddr = '0; awsize = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_gpio_out", gpio_out, 28'h0);
    chk("rst_gpio_oeb", gpio_oeb, 28'hFFF_FFFF);
    chk("rst_wr_cnt", wr_cnt, 16'h0);
    chk("rst_la", la_wdata, 32'h0);

    rst_l = 1'b1;
    #1;
    chk("first_cycle_awready", awready, 1'b0);
    chk("first_cycle_wready", wready, 1'b0);
    @(negedge clk);
    chk("ready_after_rst", awready & wready, 1'b1);

    do_write(3'd5, BASE, 3'd3, 64'h0000_00FF_0ABC_DEF5, 8'hFF);
    chk("t1_gpio_out_const", gpio_out, 28'hABC_DEF5);
    chk("t1_gpio_oeb_const", gpio_oeb, 28'hFFF_FF00);

    // W leads AW by three cycles
    push_exp(3'd2, BASE, 3'd3, 64'h1234_5678_9ABC_55EF, 8'h02);
    drive_w(64'h1234_5678_9ABC_55EF, 8'h02);
    handshake("hs_w_first", 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("w_held_wready", wready, 1'b0);
    chk("w_held_awready", awready, 1'b1);
    chk("w_held_no_b", bvalid, 1'b0);
    drive_aw(3'd2, BASE, 3'd3);
    handshake("hs_aw_late", 1'b1, 1'b0);
    chk("late_exec_bvalid", bvalid, 1'b0);
    @(negedge clk);
    check_b();
    chk("t2_gpio_out_const", gpio_out, 28'hABC_55F5);
    b_accept();

    do_write(3'd7, BASE + 32'h8, 3'd3, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    do_write(3'd1, BASE, 3'd4, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    do_write(3'd4, 32'h1000_0000, 3'd5, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    do_write(3'd3, BASE + 32'h4, 3'd2, 64'h0000_0F0F_1111_1111, 8'hF0);
    do_write(3'd0, BASE, 3'd3, 64'h1234_5678_CAFE_BABE, 8'h00);

    // B back-pressure
    push_exp(3'd6, BASE, 3'd2, 64'hFFFF_FFFF_8765_4321, 8'h0F);
    drive_aw(3'd6, BASE, 3'd2);
    drive_w(64'hFFFF_FFFF_8765_4321, 8'h0F);
    handshake("hs_stall", 1'b1, 1'b1);
    @(negedge clk);
    check_b();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_bvalid", bvalid, 1'b1);
      chk("stall_bid", bid, held.id);
      chk("stall_bresp", bresp, held.resp);
      chk("stall_ready", {awready, wready}, 2'b00);
    end
    b_accept();
    chk("post_hs_ready", {awready, wready}, 2'b11);
    do_write(3'd1, BASE, 3'd3, 64'hF000_000F_F000_0001, 8'hFF);

    @(negedge clk);
    force dut.u_regs.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.u_regs.cnt_q;
    cnt_m = 16'hFFFF;
    chk("cnt_preload", wr_cnt, 16'hFFFF);
    do_write(3'd2, BASE, 3'd3, 64'h0000_0001_0000_0002, 8'h11);
    chk("cnt_wrap", wr_cnt, 16'h0000);

    // Reset pulse while the response is pending
    drive_aw(3'd5, BASE, 3'd3);
    drive_w(64'h0000_00FF_0000_00FF, 8'hFF);
    handshake("hs_pre_rst", 1'b1, 1'b1);
    @(negedge clk);
    chk("pre_rst_bvalid", bvalid, 1'b1);
    #2;
    rst_l = 1'b0;
    #1;
    model_reset();
    chk("rst_resp_bvalid", bvalid, 1'b0);
    chk("rst_resp_gpio_oeb", gpio_oeb, 28'hFFF_FFFF);
    chk("rst_resp_gpio_out", gpio_out, 28'h0);
    chk("rst_resp_wr_cnt", wr_cnt, 16'h0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    do_write(3'd6, BASE, 3'd3, 64'h0000_0003_0000_0004, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
